// File: rtl/geo_pkg.sv
// geo_pkg: shared geofence widths, sorter state encoding and point record.
package geo_pkg;
    localparam int GEO_CW = 10;
    localparam int GEO_N_PTS = 6;
    localparam int GEO_VW = GEO_CW + 1;
    typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;
    typedef struct packed {
        logic [GEO_CW-1:0] x;
        logic [GEO_CW-1:0] y;
        logic [2:0] idx;
    } point_t;
endpackage

// File: rtl/geo_point_sort_cross_product.sv
// geo_point_sort_cross_product: flags a x b < 0, i.e. a strictly precedes b clockwise.
module geo_point_sort_cross_product
    import geo_pkg::*;
#(
    parameter int VW = GEO_VW
) (
    input  logic signed [VW-1:0] a_x,
    input  logic signed [VW-1:0] a_y,
    input  logic signed [VW-1:0] b_x,
    input  logic signed [VW-1:0] b_y,
    output logic                 neg
);
    logic signed [2*VW-1:0] p_ab, p_ba;
    assign p_ab = a_x * b_y;
    assign p_ba = a_y * b_x;
    assign neg = p_ab < p_ba;
endmodule

// File: rtl/geo_point_sort.sv
// geo_point_sort: loads N points, bubble-sorts 1..N-1 clockwise around point 0, streams them out.
module geo_point_sort
    import geo_pkg::*;
#(
    parameter int N_PTS = GEO_N_PTS,
    parameter int CW = GEO_CW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_x,
    input  logic [CW-1:0] in_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic [2:0]    out_idx,
    output logic          out_last,
    output logic          busy
);
    localparam int VW = CW + 1;
    localparam logic [2:0] LAST = 3'(N_PTS - 1);

    state_t state, state_nx;
    logic armed, in_acc, out_acc, lt, pass_end, sort_done;
    logic [2:0] lc, p, j, j1, oc;
    logic [CW-1:0] px [N_PTS];
    logic [CW-1:0] py [N_PTS];
    logic [2:0] pidx [N_PTS];
    logic signed [VW-1:0] vx [N_PTS];
    logic signed [VW-1:0] vy [N_PTS];

    assign in_acc = in_valid && in_ready;
    assign out_acc = out_valid && out_ready;
    assign j1 = j + 3'd1;
    assign pass_end = j == 3'(N_PTS - 2) - p;
    assign sort_done = pass_end && p == 3'(N_PTS - 3);

    geo_point_sort_cross_product #(.VW(VW)) u_cmp (
        .a_x(vx[j1]),
        .a_y(vy[j1]),
        .b_x(vx[j]),
        .b_y(vy[j]),
        .neg(lt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_acc ? LOAD : IDLE;
            LOAD:    state_nx = in_acc && lc == LAST ? SORT : LOAD;
            SORT:    state_nx = sort_done ? OUT : SORT;
            OUT:     state_nx = out_acc && out_last ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = armed && (state == IDLE || state == LOAD);
        busy = state == SORT || state == OUT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 1'b0;
            lc <= '0;
            p <= '0;
            j <= '0;
            oc <= '0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_x <= '0;
            out_y <= '0;
            out_idx <= '0;
        end else begin
            armed <= 1'b1;
            lc <= in_acc ? (lc == LAST ? 3'd0 : lc + 3'd1) : lc;
            j <= state == SORT && !pass_end ? j1 : 3'd1;
            p <= state == SORT ? (pass_end ? p + 3'd1 : p) : 3'd0;
            if (state != OUT) oc <= '0;
            else if (!out_valid || out_acc) begin
                if (out_acc && out_last) begin
                    out_valid <= 1'b0;
                    out_last <= 1'b0;
                end else begin
                    out_valid <= 1'b1;
                    out_x <= px[oc];
                    out_y <= py[oc];
                    out_idx <= pidx[oc];
                    out_last <= oc == LAST;
                    oc <= oc + 3'd1;
                end
            end
        end
    end

    // lc is 0 in IDLE, so the anchor lands in slot 0; its own vector is never read
    always_ff @(posedge clk) begin
        if (in_acc) begin
            px[lc] <= in_x;
            py[lc] <= in_y;
            pidx[lc] <= lc;
            vx[lc] <= {1'b0, in_x} - {1'b0, px[0]};
            vy[lc] <= {1'b0, in_y} - {1'b0, py[0]};
        end else if (state == SORT && lt) begin
            px[j] <= px[j1];
            px[j1] <= px[j];
            py[j] <= py[j1];
            py[j1] <= py[j];
            pidx[j] <= pidx[j1];
            pidx[j1] <= pidx[j];
            vx[j] <= vx[j1];
            vx[j1] <= vx[j];
            vy[j] <= vy[j1];
            vy[j1] <= vy[j];
        end
    end
endmodule

// File: tb/tb_geo_point_sort.sv
// tb_geo_point_sort: random and directed lists against a bubble-sort reference with a scoreboard monitor.
module tb_geo_point_sort;
    import geo_pkg::*;
    localparam int N = GEO_N_PTS;

    typedef struct {
        int x;
        int y;
        int i;
        int vx;
        int vy;
    } rec_t;

    logic clk = 0, reset_n = 1, in_valid = 0, out_ready = 1;
    logic in_ready, out_valid, out_last, busy;
    logic [GEO_CW-1:0] in_x = 0, in_y = 0, out_x, out_y;
    logic [2:0] out_idx;

    int checks = 0, errors = 0;
    int lx[N], ly[N], mx[N], my[N], mi[N];
    point_t exp_q[$];
    bit last_q[$];
    int got_idx[$];
    int stall_beat = 0, stall_len = 0, stall_cnt = 0, beat_no = 0;
    bit held = 0;
    logic [GEO_CW-1:0] hx, hy;
    logic [2:0] hi;

    geo_point_sort dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // reference: vectors from the anchor, fixed bubble passes, swap only when a x b < 0
    task automatic model();
        rec_t r[N];
        rec_t t;
        for (int k = 0; k < N; k++) r[k] = '{lx[k], ly[k], k, lx[k] - lx[0], ly[k] - ly[0]};
        for (int pp = 0; pp <= N - 3; pp++)
            for (int jj = 1; jj <= N - 2 - pp; jj++)
                if (r[jj+1].vx * r[jj].vy - r[jj+1].vy * r[jj].vx < 0) begin
                    t = r[jj];
                    r[jj] = r[jj+1];
                    r[jj+1] = t;
                end
        for (int k = 0; k < N; k++) begin
            mx[k] = r[k].x;
            my[k] = r[k].y;
            mi[k] = r[k].i;
        end
    endtask

    task automatic push_model();
        point_t e;
        model();
        for (int k = 0; k < N; k++) begin
            e.x = GEO_CW'(mx[k]);
            e.y = GEO_CW'(my[k]);
            e.idx = 3'(mi[k]);
            exp_q.push_back(e);
            last_q.push_back(k == N - 1);
        end
    endtask

    task automatic rand_list();
        for (int k = 0; k < N; k++) begin
            lx[k] = $urandom_range(0, 1023);
            ly[k] = $urandom_range(0, 1023);
        end
    endtask

    task automatic drive_points(input bit gaps);
        int t;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            if (gaps && k > 0) begin
                in_valid = 0;
                @(negedge clk);
            end
            in_valid = 1;
            in_x = GEO_CW'(lx[k]);
            in_y = GEO_CW'(ly[k]);
            t = 0;
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) chk("in_ready_timeout", 0, 1);
            @(posedge clk);
        end
    endtask

    // hold keeps presenting the next list's anchor to exercise the overrun case
    task automatic measure_lat(input bit hold);
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (hold) begin
                in_valid = 1;
                in_x = GEO_CW'(lx[0]);
                in_y = GEO_CW'(ly[0]);
            end else in_valid = 0;
            if (out_valid || cnt > 50) break;
            cnt++;
        end
        chk("latency", cnt, 11);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
    endtask

    task automatic chk_zero_outputs();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_idx", out_idx, 0);
    endtask

    initial begin : monitor
        point_t e;
        bit el;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                beat_no = 0;
                stall_cnt = 0;
                held = 0;
                out_ready = 1;
            end else begin
                if (busy) chk("in_ready_while_busy", in_ready, 0);
                if (held) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_x", out_x, hx);
                    chk("stall_y", out_y, hy);
                    chk("stall_idx", out_idx, hi);
                end
                out_ready = !(out_valid && stall_len > 0 && beat_no == stall_beat && stall_cnt < stall_len);
                if (!out_ready) stall_cnt++;
                held = out_valid && !out_ready;
                hx = out_x;
                hy = out_y;
                hi = out_idx;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        el = last_q.pop_front();
                        chk("out_x", out_x, e.x);
                        chk("out_y", out_y, e.y);
                        chk("out_idx", out_idx, e.idx);
                        chk("out_last", out_last, el);
                    end
                    got_idx.push_back(out_idx);
                    if (out_last) begin
                        beat_no = 0;
                        stall_cnt = 0;
                    end else beat_no++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p1, p2;
        point_t e;
        #1 reset_n = 0;
        repeat (3) @(negedge clk);
        chk_zero_outputs();
        reset_n = 1;

        lx = '{500, 600, 500, 400, 500, 600};
        ly = '{500, 500, 400, 500, 600, 600};
        push_model();
        drive_points(0);
        measure_lat(0);
        drain();

        // half-plane list is totally ordered, so its sorted form must pass through unchanged
        lx[0] = 500;
        ly[0] = 500;
        for (int k = 1; k < N; k++) begin
            lx[k] = $urandom_range(501, 900);
            ly[k] = $urandom_range(100, 900);
        end
        model();
        lx = mx;
        ly = my;
        for (int k = 0; k < N; k++) begin
            e.x = GEO_CW'(lx[k]);
            e.y = GEO_CW'(ly[k]);
            e.idx = 3'(k);
            exp_q.push_back(e);
            last_q.push_back(k == N - 1);
        end
        drive_points(0);
        measure_lat(0);
        drain();

        lx = '{500, 510, 520, 500, 400, 500};
        ly = '{500, 500, 500, 400, 500, 600};
        got_idx.delete();
        push_model();
        drive_points(0);
        measure_lat(0);
        drain();
        p1 = -1;
        p2 = -1;
        foreach (got_idx[k]) begin
            if (got_idx[k] == 1) p1 = k;
            if (got_idx[k] == 2) p2 = k;
        end
        chk("collinear_order", int'(p1 >= 0 && p1 < p2), 1);

        rand_list();
        stall_beat = 3;
        stall_len = 7;
        push_model();
        drive_points(0);
        measure_lat(0);
        drain();
        stall_len = 0;

        rand_list();
        push_model();
        drive_points(1);
        rand_list();
        push_model();
        measure_lat(1);
        drive_points(0);
        measure_lat(0);
        drain();

        rand_list();
        drive_points(0);
        @(negedge clk);
        in_valid = 0;
        repeat (3) @(posedge clk);
        #2 reset_n = 0;
        #1 chk_zero_outputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        rand_list();
        push_model();
        drive_points(0);
        measure_lat(0);
        drain();

        repeat (12) begin
            rand_list();
            stall_beat = $urandom_range(0, N - 1);
            stall_len = $urandom_range(0, 4);
            push_model();
            drive_points(1'($urandom_range(0, 1)));
            measure_lat(0);
            drain();
        end
        stall_len = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
